// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bi, with borrow out.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bi,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_a ^ i_b ^ i_bi;
  assign o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock.
// The design has a start/busy/done handshake and registered result outputs.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         Bout,
  output logic         V
);

  localparam int unsigned CW = $clog2(W) + 1;

  state_e          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic [W-1:0]    r_d;
  logic            r_br;
  logic            r_bout;
  logic            r_v;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_cnt;
  logic            w_d;
  logic            w_bo;

  full_subtractor u_fs (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_bi (r_br),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_d, r_res[W-1:1]};
          r_br  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          // Last bit: r_br is still the borrow into the MSB, needed for V.
          if (r_cnt == CW'(W - 1)) begin
            r_d     <= {w_d, r_res[W-1:1]};
            r_bout  <= w_bo;
            r_v     <= r_br ^ w_bo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bout = r_bout;
  assign V    = r_v;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4) against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy, done, Bout, V;
  logic [W-1:0] D;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_d = '0;
  logic         last_bout = 1'b0;
  logic         last_v = 1'b0;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {V, Bout, D} from plain integer arithmetic on unsigned and signed views.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    int ua, ub, sa, sb, ud, sd;
    logic [W-1:0] d;
    logic bo, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    ud = ua - ub - int'(bin);
    sd = sa - sb - int'(bin);
    d  = W'((ud + (1 << W)) % (1 << W));
    bo = (ud < 0);
    v  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    return {v, bo, d};
  endfunction

  // Entry: at a negedge with A/B/Bin driven and start=1. Returns at the negedge of the
  // done cycle (chain=1, next op already requested) or one cycle later (chain=0).
  task automatic expect_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic bin, input bit mid_start, input bit chain,
                           input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin);
    logic [W+1:0] exp;
    exp = ref_sub(a, b, bin);
    @(negedge clk);
    start = 1'b0;
    A   = W'($urandom);
    B   = W'($urandom);
    Bin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done_early"}, 32'(done), 32'd0);
      chk({tag, " d_hold"}, 32'(D), 32'(last_d));
      chk({tag, " bout_hold"}, 32'(Bout), 32'(last_bout));
      chk({tag, " v_hold"}, 32'(V), 32'(last_v));
      start = mid_start && (i == 1);
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " D"}, 32'(D), 32'(exp[W-1:0]));
    chk({tag, " Bout"}, 32'(Bout), 32'(exp[W]));
    chk({tag, " V"}, 32'(V), 32'(exp[W+1]));
    last_d    = exp[W-1:0];
    last_bout = exp[W];
    last_v    = exp[W+1];
    if (chain) begin
      A = na;
      B = nb;
      Bin = nbin;
      start = 1'b1;
    end else begin
      start = 1'b0;
      @(negedge clk);
      chk({tag, " done_width"}, 32'(done), 32'd0);
      chk({tag, " idle_busy"}, 32'(busy), 32'd0);
      chk({tag, " d_after"}, 32'(D), 32'(last_d));
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a;
    B = b;
    Bin = bin;
    start = 1'b1;
  endtask

  initial begin
    int order[512];
    int j, tmp, cur, nxt;
    bit ch;

    // Reset state
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst D", 32'(D), 32'd0);
    chk("rst Bout", 32'(Bout), 32'd0);
    chk("rst V", 32'(V), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    launch(4'b0101, 4'b0110, 1'b0);
    expect_op("t1", 4'b0101, 4'b0110, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("t1 D_const", 32'(D), 32'hF);
    launch(4'b1001, 4'b0111, 1'b1);
    expect_op("t2a", 4'b1001, 4'b0111, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("t2a V_const", 32'(V), 32'd1);
    launch(4'b1000, 4'b0001, 1'b0);
    expect_op("t2b", 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    launch(4'b0000, 4'b0000, 1'b1);
    expect_op("t3a", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    launch(4'b1111, 4'b1111, 1'b0);
    expect_op("t3b", 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Back-to-back via start in DONE, then a start pulse while busy
    launch(4'b0101, 4'b0110, 1'b0);
    expect_op("t4a", 4'b0101, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
    expect_op("t4b", 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("t4b D_const", 32'(D), 32'h2);
    launch(4'b0101, 4'b0110, 1'b0);
    expect_op("t4c", 4'b0101, 4'b0110, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Asynchronous reset at shift edge 2
    launch(4'b1001, 4'b0111, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 done", 32'(done), 32'd0);
    chk("t5 D", 32'(D), 32'd0);
    chk("t5 Bout", 32'(Bout), 32'd0);
    chk("t5 V", 32'(V), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5 no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    last_d = '0;
    last_bout = 1'b0;
    last_v = 1'b0;
    @(negedge clk);
    launch(4'b0101, 4'b0110, 1'b0);
    expect_op("t5 fresh", 4'b0101, 4'b0110, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Shuffled sweep of every {A,B,Bin}, randomly chained back-to-back
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    ch = 1'b0;
    for (int k = 0; k < 512; k++) begin
      cur = order[k];
      if (!ch) launch(W'(cur >> (W + 1)), W'(cur >> 1), 1'(cur));
      nxt = (k < 511) ? order[k + 1] : 0;
      ch = (k < 511) && ($urandom_range(0, 1) == 1);
      expect_op("sweep", W'(cur >> (W + 1)), W'(cur >> 1), 1'(cur), 1'b0, ch,
                W'(nxt >> (W + 1)), W'(nxt >> 1), 1'(nxt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
